hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

- Parametrised pipeline hazard controller.
- Placed between decode and the execute/memory/writeback stages.
- Tracks in-flight destination registers in a shadow pipeline and per-register pending bits for long-latency units (FDIV/FSQRT), and computes, for each decode operand:
  - a forwarding source select;
  - a stall request.
- Owns branch-flush sequencing and I/O-busy stalls.

## Interface
Parameters:
- NSTAGE, 3, forwarding stages after decode (1=exec, 2=ma, 3=wb)
- NSRC, 3, source operands per instruction (d, s, t)
- ADDR_W, 6, register index; bit 5 = FPR select, bits 4:0 = number
- LAT_W, 2, width of dec_lat; values 1..NSTAGE
- MAX_LR, 4, max outstanding long-latency ops
- FLUSH_CYC, 3, cycles flush stays high after a taken branch
- SEL_W, $clog2(NSTAGE+2), derived, forward-select width

Ports (reset is synchronous and active-high):
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous reset, active-high
- dec_valid  in  1  decode holds an instruction
- dec_src_addr  in  NSRC*ADDR_W  source indices, operand i at [i*ADDR_W +: ADDR_W]
- dec_src_used  in  NSRC  operand i is read
- dec_dst_addr  in  ADDR_W  destination index
- dec_dst_we  in  1  instruction writes dec_dst_addr
- dec_lat  in  LAT_W  stage index at which the result becomes forwardable (load = 2)
- dec_long  in  1  destination is written by the long-latency unit
- dec_io_wait  in  1  in/out instruction whose port is busy
- lr_done  in  1  long-latency result on result bus this cycle
- lr_dst  in  ADDR_W  destination of the lr_done result
- branch_taken  in  1  exec-stage branch/jump redirects PC
- stall  out  1  hold PC and decode
- issue  out  1  decode instruction enters exec at next edge
- flush  out  1  kill fetch/decode contents
- fwd_sel  out  NSRC*SEL_W  per operand: 0 = register file, k = stage k (1..NSTAGE), NSTAGE+1 = long-latency bus
- lr_count  out  $clog2(MAX_LR+1)  outstanding long ops

## Operation
- **Shadow pipeline.**
  - NSTAGE entries {v, dst, lat}.
  - Entry 1 loads {issue & dec_dst_we & ~dec_long, dec_dst_addr, dec_lat}.
  - Entry k+1 ← entry k every cycle; downstream never stalls, and a stall inserts a bubble (v=0).
- **Pending bitmap.** There are 2^ADDR_W pending bits.
  - A bit is set on issue & dec_dst_we & dec_long.
  - A bit is cleared on lr_done for lr_dst.
  - If set and clear hit the same index in the same cycle, set wins.
- **lr_count.**
  - +1 on a long issue, −1 on lr_done.
  - Both in the same cycle: count unchanged.
- **Register zero.** Index 0 (GPR r0) never matches any entry or pending bit; fwd_sel = 0.
- **Per used operand i with address a**, first match in this priority order:
  1. Youngest valid entry k with dst==a (smallest k):
     - k ≥ lat → fwd_sel_i = k;
     - otherwise → hazard.
  2. lr_done & lr_dst==a → fwd_sel_i = NSTAGE+1.
  3. pending[a] → hazard.
  4. Else fwd_sel_i = 0.
- **Unused operands.** fwd_sel = 0 and never cause a hazard.
- **Long-op write conflict.** dec_long & dec_dst_we with pending[dst] set (and not cleared this cycle), or lr_count==MAX_LR without lr_done → hazard.
- **Output equations.**
  - stall = dec_valid & ~flush & (any hazard | dec_io_wait)
  - issue = dec_valid & ~flush & ~stall
- **Flush.**
  - flush = branch_taken | (fcnt≠0).
  - On branch_taken, fcnt ← FLUSH_CYC−1; otherwise it decrements toward 0.
  - A branch during an active flush reloads fcnt.
  - Flush suppresses issue, so no shadow entry is created.
  - Existing shadow entries and pending bits are kept, since they belong to older instructions.

## Timing
- stall, issue, fwd_sel and flush are combinational from inputs and state in the same cycle.
- Shadow, pending, lr_count and fcnt update at posedge.
- Minimum stall for a load (lat=2) followed by a dependent instruction: 1 cycle.
- Long-op consumer: stalls until the lr_done cycle, then issues that cycle with fwd_sel = NSTAGE+1.
- Reset (rst high at posedge): all entries v=0, pending=0, lr_count=0, fcnt=0.
- While rst is high, stall, issue, flush and fwd_sel are forced to 0.
- Reset mid-operation discards all tracking; a late lr_done for a cleared register is ignored, and lr_count saturates at 0.
- lr_done with lr_count==MAX_LR and a simultaneous long issue is allowed.

## Test plan
- **ALU chain:** issue r3←(lat 1), then next cycle read r3 → stall=0, fwd_sel=1; next cycle read r3 → fwd_sel=2.
- **Load-use:** issue load r5 (lat 2), then next cycle read r5 → stall=1 for exactly 1 cycle, then issue with fwd_sel=2.
- **Long op:**
  - Issue fdiv f2 (index 34, dec_long) → pending[34]=1, lr_count=1.
  - A reader of f2 stalls until lr_done with lr_dst=34, issues that cycle with fwd_sel=4, and pending clears.
- **Capacity:**
  - Issue 4 long ops to distinct registers → 5th long op stalls with lr_count=4.
  - lr_done releases it in the same cycle; lr_count stays 4.
- **Branch:** branch_taken at cycle t with dec_valid=1 → flush=1 for t..t+2, issue=0, stall=0; a second branch at t+1 extends flush through t+3.
- **Reset/r0:**
  - rst mid-long-op → pending cleared, a reader of that register issues immediately.
  - Writes to r0 followed by reads of r0 → fwd_sel=0, no stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller between decode and exec/ma/wb.
// Tracks in-flight destinations in a shadow pipeline and outstanding
// long-latency destinations in a pending bitmap. For each decode operand
// it produces a forwarding select and a stall request, and it also
// sequences branch flushes.
module hazard_scoreboard #(
    parameter int NSTAGE    = 3,
    parameter int NSRC      = 3,
    parameter int ADDR_W    = 6,
    parameter int LAT_W     = 2,
    parameter int MAX_LR    = 4,
    parameter int FLUSH_CYC = 3,
    parameter int SEL_W     = $clog2(NSTAGE+2)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          dec_valid,
    input  logic [NSRC*ADDR_W-1:0]        dec_src_addr,
    input  logic [NSRC-1:0]               dec_src_used,
    input  logic [ADDR_W-1:0]             dec_dst_addr,
    input  logic                          dec_dst_we,
    input  logic [LAT_W-1:0]              dec_lat,
    input  logic                          dec_long,
    input  logic                          dec_io_wait,
    input  logic                          lr_done,
    input  logic [ADDR_W-1:0]             lr_dst,
    input  logic                          branch_taken,
    output logic                          stall,
    output logic                          issue,
    output logic                          flush,
    output logic [NSRC*SEL_W-1:0]         fwd_sel,
    output logic [$clog2(MAX_LR+1)-1:0]   lr_count
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(MAX_LR+1);
    localparam int FC_W  = $clog2(FLUSH_CYC+1);

    logic [NSTAGE:1]    sh_v;
    logic [ADDR_W-1:0]  sh_dst [1:NSTAGE];
    logic [LAT_W-1:0]   sh_lat [1:NSTAGE];
    logic [NREG-1:0]    pending;
    logic [FC_W-1:0]    fcnt;

    logic               flush_c;
    logic               hazard;
    logic               long_hz;
    logic               stall_c;
    logic               issue_c;
    logic               long_issue;
    logic [ADDR_W-1:0]  src;
    logic [SEL_W-1:0]   sel;
    logic               found;
    logic               hz;
    logic [NSRC*SEL_W-1:0] fwd_c;

    // Operand lookup: youngest shadow entry first, then the long-latency
    // result bus, then the pending bitmap. A stalled operand reports 0.
    always_comb begin
        hazard = 1'b0;
        fwd_c  = '0;
        src    = '0;
        sel    = '0;
        found  = 1'b0;
        hz     = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            src   = dec_src_addr[i*ADDR_W +: ADDR_W];
            sel   = '0;
            found = 1'b0;
            hz    = 1'b0;
            if (dec_src_used[i] && src != '0) begin
                for (int unsigned k = 1; k <= NSTAGE; k++) begin
                    if (!found && sh_v[k] && sh_dst[k] == src) begin
                        found = 1'b1;
                        if (k >= int'(sh_lat[k])) sel = SEL_W'(k);
                        else                      hz  = 1'b1;
                    end
                end
                if (!found) begin
                    if (lr_done && lr_dst == src) sel = SEL_W'(NSTAGE+1);
                    else if (pending[src])        hz  = 1'b1;
                end
            end
            fwd_c[i*SEL_W +: SEL_W] = sel;
            hazard = hazard | hz;
        end
        long_hz = dec_long & dec_dst_we &
                  (((dec_dst_addr != '0) & pending[dec_dst_addr] &
                    ~(lr_done & (lr_dst == dec_dst_addr))) |
                   ((lr_count == CNT_W'(MAX_LR)) & ~lr_done));
    end

    // Issue/stall/flush decision; all outputs held low during reset.
    always_comb begin
        flush_c    = branch_taken | (fcnt != '0);
        stall_c    = dec_valid & ~flush_c & (hazard | long_hz | dec_io_wait);
        issue_c    = dec_valid & ~flush_c & ~stall_c;
        long_issue = issue_c & dec_dst_we & dec_long;
        stall      = ~rst & stall_c;
        issue      = ~rst & issue_c;
        flush      = ~rst & flush_c;
        fwd_sel    = rst ? '0 : fwd_c;
    end

    // Shadow pipeline: entry 1 captures the issuing short-latency writer,
    // older entries shift down unconditionally.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_v <= '0;
        end else begin
            sh_v[1] <= issue_c & dec_dst_we & ~dec_long;
            for (int unsigned k = 2; k <= NSTAGE; k++) sh_v[k] <= sh_v[k-1];
        end
        sh_dst[1] <= dec_dst_addr;
        sh_lat[1] <= dec_lat;
        for (int unsigned k = 2; k <= NSTAGE; k++) begin
            sh_dst[k] <= sh_dst[k-1];
            sh_lat[k] <= sh_lat[k-1];
        end
    end

    // Pending bitmap and outstanding count; a same-cycle set beats the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            lr_count <= '0;
        end else begin
            if (lr_done)    pending[lr_dst]       <= 1'b0;
            if (long_issue) pending[dec_dst_addr] <= 1'b1;
            if (long_issue && !lr_done && lr_count != CNT_W'(MAX_LR))
                lr_count <= lr_count + 1'b1;
            else if (lr_done && !long_issue && lr_count != '0)
                lr_count <= lr_count - 1'b1;
        end
    end

    // Flush counter: reload on every taken branch, else count down to 0.
    always_ff @(posedge clk) begin
        if (rst)               fcnt <= '0;
        else if (branch_taken) fcnt <= FC_W'(FLUSH_CYC-1);
        else if (fcnt != '0)   fcnt <= fcnt - 1'b1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// random traffic, every cycle compared against a cycle-indexed history model.
module tb_hazard_scoreboard;

    localparam int NSTAGE = 3, NSRC = 3, ADDR_W = 6, LAT_W = 2;
    localparam int MAX_LR = 4, FLUSH_CYC = 3, SEL_W = 3, CNT_W = 3;

    logic clk = 1'b0;
    logic rst;
    logic dec_valid;
    logic [NSRC*ADDR_W-1:0] dec_src_addr;
    logic [NSRC-1:0] dec_src_used;
    logic [ADDR_W-1:0] dec_dst_addr;
    logic dec_dst_we;
    logic [LAT_W-1:0] dec_lat;
    logic dec_long, dec_io_wait, lr_done, branch_taken;
    logic [ADDR_W-1:0] lr_dst;
    logic stall, issue, flush;
    logic [NSRC*SEL_W-1:0] fwd_sel;
    logic [CNT_W-1:0] lr_count;

    hazard_scoreboard #(.NSTAGE(NSTAGE), .NSRC(NSRC), .ADDR_W(ADDR_W), .LAT_W(LAT_W),
                        .MAX_LR(MAX_LR), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src_addr(dec_src_addr),
        .dec_src_used(dec_src_used), .dec_dst_addr(dec_dst_addr), .dec_dst_we(dec_dst_we),
        .dec_lat(dec_lat), .dec_long(dec_long), .dec_io_wait(dec_io_wait),
        .lr_done(lr_done), .lr_dst(lr_dst), .branch_taken(branch_taken),
        .stall(stall), .issue(issue), .flush(flush), .fwd_sel(fwd_sel), .lr_count(lr_count));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stimulus variables for the next cycle.
    bit           s_rst, s_dv, s_we, s_long, s_io, s_ld, s_br;
    int unsigned  s_src [NSRC];
    bit           s_used [NSRC];
    int unsigned  s_dst, s_lat, s_ldst;

    // Reference model: history of issued short-latency writers keyed by cycle,
    // a 64-entry pending table, an outstanding counter, and cycle stamps.
    int           cyc = 0;
    int           last_rst = -100;
    int           last_br  = -100;
    bit           hv [int];
    int unsigned  hd [int];
    int unsigned  hl [int];
    bit           pend [64];
    int           lrc = 0;

    task automatic idle();
        s_rst = 0; s_dv = 0; s_we = 0; s_long = 0; s_io = 0; s_ld = 0; s_br = 0;
        s_dst = 0; s_lat = 1; s_ldst = 0;
        for (int i = 0; i < NSRC; i++) begin s_src[i] = 0; s_used[i] = 0; end
    endtask

    task automatic step();
        bit e_flush, e_stall, e_issue, haz, found;
        int unsigned e_sel [NSRC];
        int c;
        @(negedge clk);
        rst = s_rst; dec_valid = s_dv; dec_dst_we = s_we; dec_long = s_long;
        dec_io_wait = s_io; lr_done = s_ld; branch_taken = s_br;
        dec_dst_addr = ADDR_W'(s_dst); dec_lat = LAT_W'(s_lat); lr_dst = ADDR_W'(s_ldst);
        for (int i = 0; i < NSRC; i++) begin
            dec_src_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(s_src[i]);
            dec_src_used[i] = s_used[i];
        end
        #1;
        check("lr_count", lr_count, lrc);
        if (s_rst) begin
            check("rst_stall", stall, 0);
            check("rst_issue", issue, 0);
            check("rst_flush", flush, 0);
            check("rst_fwd", fwd_sel, 0);
            for (int r = 0; r < 64; r++) pend[r] = 0;
            lrc = 0;
            last_rst = cyc;
            cyc++;
            return;
        end
        e_flush = s_br || (last_br > last_rst && cyc - last_br < FLUSH_CYC);
        haz = 0;
        for (int i = 0; i < NSRC; i++) begin
            e_sel[i] = 0;
            found = 0;
            if (s_used[i] && s_src[i] != 0) begin
                for (int k = 1; k <= NSTAGE; k++) begin
                    c = cyc - k;
                    if (!found && c > last_rst && hv.exists(c) && hv[c] && hd[c] == s_src[i]) begin
                        found = 1;
                        if (k >= int'(hl[c])) e_sel[i] = k; else haz = 1;
                    end
                end
                if (!found) begin
                    if (s_ld && s_ldst == s_src[i]) e_sel[i] = NSTAGE + 1;
                    else if (pend[s_src[i]]) haz = 1;
                end
            end
        end
        if (s_long && s_we) begin
            if (s_dst != 0 && pend[s_dst] && !(s_ld && s_ldst == s_dst)) haz = 1;
            if (lrc == MAX_LR && !s_ld) haz = 1;
        end
        e_stall = s_dv && !e_flush && (haz || s_io);
        e_issue = s_dv && !e_flush && !e_stall;
        check("flush", flush, e_flush);
        check("stall", stall, e_stall);
        check("issue", issue, e_issue);
        for (int i = 0; i < NSRC; i++)
            check($sformatf("fwd%0d", i), fwd_sel[i*SEL_W +: SEL_W], e_sel[i]);
        // Advance model to the next cycle.
        hv[cyc] = e_issue && s_we && !s_long;
        hd[cyc] = s_dst;
        hl[cyc] = s_lat;
        if (hv.exists(cyc - 8)) begin hv.delete(cyc - 8); hd.delete(cyc - 8); hl.delete(cyc - 8); end
        if (s_ld) pend[s_ldst] = 0;
        if (e_issue && s_we && s_long) begin
            pend[s_dst] = 1;
            if (!s_ld) lrc++;
        end else if (s_ld && lrc > 0) begin
            lrc--;
        end
        if (s_br) last_br = cyc;
        cyc++;
    endtask

    task automatic read0(input int unsigned a);
        idle(); s_dv = 1; s_used[0] = 1; s_src[0] = a;
    endtask

    int unsigned pool [8] = '{0, 3, 5, 34, 35, 40, 7, 32};

    initial begin
        idle();
        s_rst = 1; step(); step();

        // ALU chain on r3.
        idle(); s_dv = 1; s_we = 1; s_dst = 3; s_lat = 1; step();
        read0(3); step();
        check("alu_fwd1", fwd_sel[2:0], 1); check("alu_nostall", stall, 0);
        read0(3); step();
        check("alu_fwd2", fwd_sel[2:0], 2);

        // Load-use on r5.
        idle(); s_dv = 1; s_we = 1; s_dst = 5; s_lat = 2; step();
        read0(5); step(); check("load_stall", stall, 1);
        read0(5); step(); check("load_fwd", fwd_sel[2:0], 2); check("load_issue", issue, 1);

        // Long op to f2 (index 34).
        idle(); s_dv = 1; s_we = 1; s_long = 1; s_dst = 34; step();
        read0(34); step(); check("long_stall", stall, 1); check("long_cnt", lr_count, 1);
        read0(34); step(); check("long_stall2", stall, 1);
        read0(34); s_ld = 1; s_ldst = 34; step();
        check("long_fwd", fwd_sel[2:0], 4); check("long_issue", issue, 1);
        read0(34); step(); check("long_clear", stall, 0); check("long_cnt0", lr_count, 0);

        // Capacity: four outstanding, fifth waits, released by lr_done.
        for (int j = 0; j < 4; j++) begin
            idle(); s_dv = 1; s_we = 1; s_long = 1; s_dst = 40 + j; step();
        end
        idle(); s_dv = 1; s_we = 1; s_long = 1; s_dst = 44; step();
        check("cap_stall", stall, 1); check("cap_cnt", lr_count, 4);
        s_ld = 1; s_ldst = 40; step(); check("cap_issue", issue, 1);
        idle(); step(); check("cap_cnt_hold", lr_count, 4);
        for (int j = 1; j < 5; j++) begin idle(); s_ld = 1; s_ldst = 40 + j; step(); end

        // Branch flush and extension.
        idle(); s_dv = 1; s_br = 1; step();
        check("br_flush", flush, 1); check("br_issue", issue, 0); check("br_stall", stall, 0);
        step(); check("br_flush1", flush, 1);
        s_br = 0; step(); check("br_flush2", flush, 1);
        step(); check("br_flush3", flush, 1);
        step(); check("br_done", flush, 0); check("br_resume", issue, 1);

        // Reset during a long op, then late lr_done.
        idle(); s_dv = 1; s_we = 1; s_long = 1; s_dst = 35; step();
        idle(); s_rst = 1; step();
        read0(35); step(); check("rst_reader", issue, 1);
        idle(); s_ld = 1; s_ldst = 35; step();
        idle(); step(); check("rst_cnt_sat", lr_count, 0);

        // Register zero never forwards or stalls.
        idle(); s_dv = 1; s_we = 1; s_dst = 0; s_lat = 2; step();
        read0(0); step(); check("r0_fwd", fwd_sel[2:0], 0); check("r0_stall", stall, 0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            idle();
            s_rst = ($urandom_range(0, 199) == 0);
            s_dv  = ($urandom_range(0, 9) < 8);
            s_we  = $urandom_range(0, 1);
            s_long = s_we && ($urandom_range(0, 7) == 0);
            s_dst = pool[$urandom_range(0, 7)];
            s_lat = $urandom_range(1, 3);
            s_io  = ($urandom_range(0, 9) == 0);
            s_ld  = ($urandom_range(0, 3) == 0);
            s_ldst = pool[$urandom_range(0, 7)];
            s_br  = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NSRC; i++) begin
                s_used[i] = $urandom_range(0, 1);
                s_src[i]  = pool[$urandom_range(0, 7)];
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
